area_seq: RTL and testbench
===========================

AREA_SEQ -- requirements
Module: area_seq

Interface
REQ-001 No parameters; widths fixed by package constants COORD_W=10, AREA_W=20, ACC_W=23.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  coordinate set presented.
REQ-005 in_ready  output  1  block accepts a coordinate set this cycle.
REQ-006 x1, y1, x2, y2, x3, y3  input  10 each  unsigned vertex coordinates.
REQ-007 out_valid  output  1  result available.
REQ-008 out_ready  input  1  consumer takes the result this cycle.
REQ-009 area  output  20  floor(|det|/2), the triangle area, truncated.
REQ-010 half  output  1  |det| bit 0; set when the true area has a .5 fraction.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, MAC, DONE; MAC carries a 2-bit step counter 0..2.
REQ-013 The SHALL definition is det = x1*(y2-y3) + x2*(y3-y1) + x3*(y1-y2), computed in signed arithmetic: differences 11-bit signed, products 21-bit signed, accumulator 23-bit signed.
REQ-014 in_ready SHALL be 1 only in IDLE; acceptance = in_valid && in_ready at a rising edge.
REQ-015 On acceptance, all six coordinates SHALL be registered, the accumulator cleared, step=0, and the state set to MAC.
REQ-016 In MAC, each edge SHALL add exactly one product term (step 0: x1 term, 1: x2 term, 2: x3 term) using one shared multiplier.
REQ-017 After step 2, the state SHALL become DONE, with area/half registered from |acc|.
REQ-018 Latency: out_valid SHALL rise exactly 4 edges after the acceptance edge (1 capture + 3 MAC), and stay constant.
REQ-019 In DONE, out_valid=1; area and half SHALL hold stable until out_valid && out_ready, then return to IDLE on that edge.
REQ-020 out_valid SHALL be 0 in IDLE and MAC; area and half keep their last value outside DONE.
REQ-021 in_valid while not IDLE SHALL be ignored, with no capture and no effect on the computation in flight.
REQ-022 Input coordinates may change after acceptance without affecting the result.
REQ-023 Negative det (clockwise vertex order) SHALL yield the same area as counter-clockwise.
REQ-024 Degenerate (collinear or coincident) vertices SHALL yield area=0, half=0.
REQ-025 Max magnitude |det| <= 1023*1023 SHALL fit; intermediate partial sums (|acc| < 2^22) SHALL never overflow ACC_W.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, step=0, acc=0, the coordinate registers to 0, area=0, half=0, out_valid=0, and busy=0; in_ready=1 once released.
REQ-027 Reset asserted mid-MAC or in DONE SHALL discard the pending result; no out_valid after release until a new acceptance.

Structure
REQ-028 Shared package area_pkg SHALL hold COORD_W, AREA_W, ACC_W and the state enum type area_state_t.
REQ-029 One combinational sub-module area_mac_term SHALL compute coord*(ya-yb) as a 21-bit signed product; it is instantiated once and multiplexed by step.
REQ-030 Controller FSM, step counter, accumulator and output registers SHALL reside in area_seq.

Verification
REQ-031 (0,0),(4,0),(0,3) accepted -> out_valid 4 edges later, area=6, half=0; clockwise (0,0),(0,3),(4,0) -> area=6, half=0.
REQ-032 (0,0),(1,0),(0,1) -> area=0, half=1; collinear (1,1),(2,2),(3,3) -> area=0, half=0.
REQ-033 (0,0),(1023,0),(0,1023) -> area=523264, half=1; (1023,1023),(0,1023),(1023,0) -> area=523264, half=1.
REQ-034 Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid, area and half stable, in_ready=0, and a new in_valid pulse ignored; out_ready=1 -> IDLE next edge.
REQ-035 rst_n pulsed low during MAC step 1 -> outputs zero immediately, no out_valid afterwards; the next transaction (0,0),(4,0),(0,3) gives area=6.
REQ-036 Back-to-back: in_valid held high with out_ready=1 -> one acceptance every 5 cycles, with results in order.

Source files
------------

// File: rtl/area_pkg.sv
// Shared widths and controller state type for the sequential triangle-area block.
package area_pkg;

    localparam int COORD_W = 10;
    localparam int AREA_W  = 20;
    localparam int ACC_W   = 23;
    localparam int DIFF_W  = COORD_W + 1;
    localparam int PROD_W  = 2 * COORD_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } area_state_t;

endpackage

// File: rtl/area_mac_term.sv
// One signed shoelace term: coord * (ya - yb), built from unsigned coordinates.
module area_mac_term
    import area_pkg::*;
(
    input  logic        [COORD_W-1:0] i_coord,
    input  logic        [COORD_W-1:0] i_ya,
    input  logic        [COORD_W-1:0] i_yb,
    output logic signed [PROD_W-1:0]  o_prod
);

    logic signed [DIFF_W-1:0] w_diff;
    logic signed [PROD_W-1:0] w_coord_ext;
    logic signed [PROD_W-1:0] w_diff_ext;

    assign w_diff      = $signed({1'b0, i_ya}) - $signed({1'b0, i_yb});
    assign w_coord_ext = $signed({{(PROD_W-COORD_W){1'b0}}, i_coord});
    assign w_diff_ext  = $signed({{(PROD_W-DIFF_W){w_diff[DIFF_W-1]}}, w_diff});
    // |coord * diff| <= 1023*1023, so the product always fits in PROD_W bits.
    assign o_prod      = w_coord_ext * w_diff_ext;

endmodule

// File: rtl/area_seq.sv
// Sequential triangle area: three shoelace terms accumulated through one shared
// multiplier, result held with valid/ready handshake until taken.
module area_seq
    import area_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    input  logic [COORD_W-1:0] x3,
    input  logic [COORD_W-1:0] y3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [AREA_W-1:0]  area,
    output logic               half,
    output logic               busy
);

    area_state_t               r_state;
    area_state_t               w_state_nxt;
    logic        [1:0]         r_step;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ACC_W-1:0]   w_acc_nxt;
    logic        [COORD_W-1:0] r_x1, r_y1, r_x2, r_y2, r_x3, r_y3;
    logic        [COORD_W-1:0] w_coord, w_ya, w_yb;
    logic signed [PROD_W-1:0]  w_prod;
    logic        [AREA_W:0]    w_mag;
    logic        [AREA_W-1:0]  r_area;
    logic                      r_half;
    logic                      w_accept;

    // Magnitude of the accumulated determinant, clamped to AREA_W+1 bits.
    function automatic logic [AREA_W:0] f_sat_mag(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-1:0] a;
        a = v[ACC_W-1] ? $unsigned(-v) : $unsigned(v);
        if (|a[ACC_W-1:AREA_W+1])
            return {(AREA_W+1){1'b1}};
        return a[AREA_W:0];
    endfunction

    assign w_accept  = in_valid && (r_state == IDLE);
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign area      = r_area;
    assign half      = r_half;

    always_comb begin
        w_coord = r_x1;
        w_ya    = r_y2;
        w_yb    = r_y3;
        case (r_step)
            2'd1: begin w_coord = r_x2; w_ya = r_y3; w_yb = r_y1; end
            2'd2: begin w_coord = r_x3; w_ya = r_y1; w_yb = r_y2; end
            default: ;
        endcase
    end

    area_mac_term u_term (
        .i_coord (w_coord),
        .i_ya    (w_ya),
        .i_yb    (w_yb),
        .o_prod  (w_prod)
    );

    assign w_acc_nxt = r_acc + ACC_W'(w_prod);
    assign w_mag     = f_sat_mag(w_acc_nxt);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)       w_state_nxt = MAC;
            MAC:     if (r_step == 2'd2) w_state_nxt = DONE;
            DONE:    if (out_ready)      w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step <= 2'd0;
            r_acc  <= '0;
            r_x1   <= '0;
            r_y1   <= '0;
            r_x2   <= '0;
            r_y2   <= '0;
            r_x3   <= '0;
            r_y3   <= '0;
            r_area <= '0;
            r_half <= 1'b0;
        end else if (w_accept) begin
            r_step <= 2'd0;
            r_acc  <= '0;
            r_x1   <= x1;
            r_y1   <= y1;
            r_x2   <= x2;
            r_y2   <= y2;
            r_x3   <= x3;
            r_y3   <= y3;
        end else if (r_state == MAC) begin
            r_acc <= w_acc_nxt;
            // The last term's sum goes straight to the output registers.
            if (r_step == 2'd2) begin
                r_step <= 2'd0;
                r_area <= w_mag[AREA_W:1];
                r_half <= w_mag[0];
            end else begin
                r_step <= r_step + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_area_seq.sv
// Directed bench for area_seq: latency, area/half values, backpressure, reset, throughput.
module tb_area_seq;
    import area_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [COORD_W-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0, x3 = '0, y3 = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [AREA_W-1:0]  area;
    logic               half;
    logic               busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    area_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .y1        (y1),
        .x2        (x2),
        .y2        (y2),
        .x3        (x3),
        .y3        (y3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .area      (area),
        .half      (half),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy);
        x1 = ax[COORD_W-1:0]; y1 = ay[COORD_W-1:0];
        x2 = bx[COORD_W-1:0]; y2 = by[COORD_W-1:0];
        x3 = cx[COORD_W-1:0]; y3 = cy[COORD_W-1:0];
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick;
            n++;
        end
        check("wait_idle", 32'(in_ready), 32'd1);
    endtask

    task automatic run_tri(input string tag, input int ax, input int ay, input int bx,
                           input int by, input int cx, input int cy,
                           input int ea, input int eh);
        wait_idle;
        set_tri(ax, ay, bx, by, cx, cy);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        set_tri(1023, 5, 7, 1023, 300, 0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        tick;
        tick;
        check({tag, "_ov_early"}, 32'(out_valid), 32'd0);
        tick;
        check({tag, "_ov"},   32'(out_valid), 32'd1);
        check({tag, "_area"}, 32'(area), 32'(ea));
        check({tag, "_half"}, 32'(half), 32'(eh));
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
        check({tag, "_ov_off"}, 32'(out_valid), 32'd0);
    endtask

    int vec [3][6];
    int exp_area [3];
    int exp_half [3];

    initial begin
        int t_prev;
        int t_acc;
        int seen_ov;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_area", 32'(area), 32'd0);
        check("rst_half", 32'(half), 32'd0);
        check("rst_ov",   32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdy",  32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick;

        run_tri("ccw",    0, 0, 4, 0, 0, 3, 6, 0);
        run_tri("cw",     0, 0, 0, 3, 4, 0, 6, 0);
        run_tri("unit",   0, 0, 1, 0, 0, 1, 0, 1);
        run_tri("colin",  1, 1, 2, 2, 3, 3, 0, 0);
        run_tri("max_a",  0, 0, 1023, 0, 0, 1023, 523264, 1);
        run_tri("max_b",  1023, 1023, 0, 1023, 1023, 0, 523264, 1);

        // Backpressure: result held while out_ready is low, new requests ignored.
        wait_idle;
        set_tri(0, 0, 4, 0, 0, 3);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick; tick; tick;
        for (int i = 0; i < 5; i++) begin
            check("bp_ov",   32'(out_valid), 32'd1);
            check("bp_area", 32'(area), 32'd6);
            check("bp_half", 32'(half), 32'd0);
            check("bp_rdy",  32'(in_ready), 32'd0);
            if (i == 2) begin
                set_tri(0, 0, 1023, 0, 0, 1023);
                in_valid = 1'b1;
            end
            tick;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("bp_ov_off", 32'(out_valid), 32'd0);
        check("bp_rdy_on", 32'(in_ready), 32'd1);
        check("bp_keep",   32'(area), 32'd6);
        tick;
        check("bp_no_cap", 32'(busy), 32'd0);

        // Reset during MAC step 1 drops the pending result.
        set_tri(0, 0, 1023, 0, 0, 1023);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        rst_n = 1'b0;
        #1;
        check("mrst_area", 32'(area), 32'd0);
        check("mrst_half", 32'(half), 32'd0);
        check("mrst_ov",   32'(out_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        tick;
        rst_n = 1'b1;
        seen_ov = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (out_valid) seen_ov++;
        end
        check("mrst_no_ov", 32'(seen_ov), 32'd0);
        check("mrst_rdy",   32'(in_ready), 32'd1);
        run_tri("after_rst", 0, 0, 4, 0, 0, 3, 6, 0);

        // Back-to-back: in_valid held high, out_ready held high.
        vec[0] = '{0, 0, 4, 0, 0, 3};       exp_area[0] = 6;      exp_half[0] = 0;
        vec[1] = '{0, 0, 1023, 0, 0, 1023}; exp_area[1] = 523264; exp_half[1] = 1;
        vec[2] = '{2, 1, 10, 1, 2, 7};      exp_area[2] = 24;     exp_half[2] = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            set_tri(vec[k][0], vec[k][1], vec[k][2], vec[k][3], vec[k][4], vec[k][5]);
            wait_idle;
            tick;
            t_acc = cyc;
            if (k > 0) check("b2b_period", 32'(t_acc - t_prev), 32'd5);
            t_prev = t_acc;
            tick;
            tick;
            check("b2b_ov_early", 32'(out_valid), 32'd0);
            tick;
            if (k == 2) in_valid = 1'b0;
            check("b2b_ov",   32'(out_valid), 32'd1);
            check("b2b_area", 32'(area), 32'(exp_area[k]));
            check("b2b_half", 32'(half), 32'(exp_half[k]));
        end
        tick;
        out_ready = 1'b0;
        check("b2b_end_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
